// File: rtl/preg_stage_hs.sv
// Pipeline boundary register with valid/ready handshake, flush and stall counter.
// Define PREG_SKID_EN for the 2-entry skid build with a registered in_ready.
module preg_stage_hs #(
   parameter int DATA_LENGTH = 32,
   parameter int CTRL_WIDTH  = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_LENGTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0]  in_ctrl,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_LENGTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0]  out_ctrl,
   output logic [CNT_WIDTH-1:0]   stall_cnt
);

   logic                 in_fire;
   logic                 out_fire;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && !out_ready && (cnt_q != '1)) begin
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;

`ifdef PREG_SKID_EN

   typedef enum logic [1:0] {
      S_EMPTY,
      S_FULL,
      S_SKID
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   rdy_q;
   logic [DATA_LENGTH-1:0] main_data_q;
   logic [DATA_LENGTH-1:0] main_data_d;
   logic [CTRL_WIDTH-1:0]  main_ctrl_q;
   logic [CTRL_WIDTH-1:0]  main_ctrl_d;
   logic [DATA_LENGTH-1:0] skid_data_q;
   logic [DATA_LENGTH-1:0] skid_data_d;
   logic [CTRL_WIDTH-1:0]  skid_ctrl_q;
   logic [CTRL_WIDTH-1:0]  skid_ctrl_d;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      unique case (state_q)
         S_EMPTY: begin
            if (in_fire) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
               state_d     = S_FULL;
            end
         end
         S_FULL: begin
            if (in_fire && out_fire) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (in_fire) begin
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
               state_d     = S_SKID;
            end else if (out_fire) begin
               main_ctrl_d = '0;
               state_d     = S_EMPTY;
            end
         end
         S_SKID: begin
            if (out_fire) begin
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
               skid_ctrl_d = '0;
               state_d     = S_FULL;
            end
         end
         default: begin
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            state_d     = S_EMPTY;
         end
      endcase
      // Flush wins: drop everything, visible payload stays put
      if (flush) begin
         main_data_d = main_data_q;
         skid_data_d = skid_data_q;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
         state_d     = S_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         rdy_q       <= 1'b1;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= (state_d != S_SKID);
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q != S_EMPTY);
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;

`else

   logic                   valid_q;
   logic                   valid_d;
   logic [DATA_LENGTH-1:0] data_q;
   logic [DATA_LENGTH-1:0] data_d;
   logic [CTRL_WIDTH-1:0]  ctrl_q;
   logic [CTRL_WIDTH-1:0]  ctrl_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (in_fire) begin
         valid_d = 1'b1;
         data_d  = in_data;
         ctrl_d  = in_ctrl;
      end else if (out_fire) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Flush always accepts so the killed beat drains from upstream
   assign in_ready  = flush || !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_ctrl  = ctrl_q;

`endif

endmodule

// File: tb/tb_preg_stage_hs.sv
// Bench for preg_stage_hs: queue model of stage contents plus directed literals.
// Works for both the default and the PREG_SKID_EN build.
module tb_preg_stage_hs;

   localparam int DW  = 32;
   localparam int CW  = 4;
   localparam int NW  = 4;
   localparam int MAX = (1 << NW) - 1;
`ifdef PREG_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [NW-1:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   preg_stage_hs #(
      .DATA_LENGTH(DW),
      .CTRL_WIDTH (CW),
      .CNT_WIDTH  (NW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ctrl (out_ctrl),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model: the stage is a FIFO of capacity 1 (base) or 2 (skid)
   logic [DW-1:0] mq_d[$];
   logic [CW-1:0] mq_c[$];
   logic [DW-1:0] m_shown = '0;
   int            m_cnt = 0;
   bit            m_inf;
   bit            m_outf;

   function automatic bit m_rdy();
      if (SKID) return (mq_d.size() < 2);
      return flush || (mq_d.size() == 0) || out_ready;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq_d.delete();
         mq_c.delete();
         m_shown = '0;
         m_cnt   = 0;
      end else begin
         m_inf  = in_valid && m_rdy();
         m_outf = (mq_d.size() > 0) && out_ready;
         if ((mq_d.size() > 0) && !out_ready && (m_cnt < MAX))
            m_cnt++;
         if (flush) begin
            mq_d.delete();
            mq_c.delete();
         end else begin
            if (m_outf) begin
               void'(mq_d.pop_front());
               void'(mq_c.pop_front());
            end
            if (m_inf) begin
               mq_d.push_back(in_data);
               mq_c.push_back(in_ctrl);
            end
         end
         if (mq_d.size() > 0) m_shown = mq_d[0];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", 64'(out_valid), 64'(mq_d.size() > 0));
         chk("in_ready", 64'(in_ready), 64'(m_rdy()));
         chk("data", 64'(out_data), 64'(m_shown));
         chk("ctrl", 64'(out_ctrl),
             (mq_c.size() > 0) ? 64'(mq_c[0]) : 64'd0);
         chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit iv, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input bit ordy,
                        input bit fl);
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic do_reset();
      drive(0, '0, '0, 0, 0);
      #1 rst = 1'b1;
      repeat (2) step();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;

      // Reset mid-stream with a held, stalled beat
      drive(1, 32'h11, 4'h5, 0, 0);
      step();
      drive(0, '0, '0, 0, 0);
      repeat (2) step();
      chk("t1_pre_cnt", 64'(stall_cnt), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("t1_valid", 64'(out_valid), 64'd0);
      chk("t1_ctrl", 64'(out_ctrl), 64'd0);
      chk("t1_cnt", 64'(stall_cnt), 64'd0);
      chk("t1_rdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // Full-rate streaming
      for (int i = 1; i <= 8; i++) begin
         drive(1, 32'(i), 4'(i), 1, 0);
         step();
         if (i == 3) begin
            chk("t2_data3", 64'(out_data), 64'd3);
            chk("t2_valid", 64'(out_valid), 64'd1);
            chk("t2_cnt", 64'(stall_cnt), 64'd0);
         end
      end
      drive(0, '0, '0, 1, 0);
      step();

      // Stall for five cycles, second beat waits behind
      do_reset();
      drive(1, 32'hA5A5_0001, 4'h3, 0, 0);
      step();
      drive(1, 32'h2, 4'h6, 0, 0);
      repeat (5) step();
      chk("t3_data", 64'(out_data), 64'hA5A5_0001);
      chk("t3_cnt", 64'(stall_cnt), 64'd5);
      chk("t3_rdy", 64'(in_ready), 64'd0);
      drive(1, 32'h2, 4'h6, 1, 0);
      step();
      chk("t3_next", 64'(out_data), 64'h2);
      drive(0, '0, '0, 1, 0);
      repeat (2) step();

      // Flush while holding a beat; the flush-cycle beat is dropped
      do_reset();
      drive(1, 32'hCAFE_0004, 4'h9, 0, 0);
      step();
      drive(1, 32'hDEAD_BEEF, 4'hF, 0, 1);
      step();
      chk("t4_valid", 64'(out_valid), 64'd0);
      chk("t4_ctrl", 64'(out_ctrl), 64'd0);
      chk("t4_data", 64'(out_data), 64'hCAFE_0004);
      drive(0, '0, '0, 1, 0);
      repeat (3) step();
      chk("t4_gone", 64'(out_valid), 64'd0);

      // Counter saturation
      do_reset();
      drive(1, 32'h55, 4'h1, 0, 0);
      step();
      drive(0, '0, '0, 0, 0);
      repeat (20) step();
      chk("t5_sat", 64'(stall_cnt), 64'd15);
      chk("t5_valid", 64'(out_valid), 64'd1);
      drive(0, '0, '0, 1, 1);
      step();
      chk("t5_keep", 64'(stall_cnt), 64'd15);

      // Random traffic
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         drive(($urandom % 4) != 0, $urandom, 4'($urandom),
               ($urandom % 3) != 0, ($urandom % 40) == 0);
         step();
      end
      drive(0, '0, '0, 1, 0);
      repeat (4) step();
      chk("drained", 64'(out_valid), 64'd0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
